// File: rtl/ascon_enc_sequencer.sv
// ascon_enc_sequencer
// Round-serial ASCON-128 encryption controller. Holds the 320-bit state and
// drives an external single-round permutation unit for one round per clock
// through INIT (12 rounds), three AD groups (6 rounds each), one plaintext
// group (6 rounds) and FINAL (12 rounds): 48 round edges per message.
module ascon_enc_sequencer (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [63:0]   iv,
   input  logic [63:0]   k0,
   input  logic [63:0]   k1,
   input  logic [63:0]   n0,
   input  logic [63:0]   n1,
   input  logic [63:0]   d0,
   input  logic [63:0]   d1,
   input  logic [63:0]   d2,
   input  logic [63:0]   pln0,
   input  logic [63:0]   pln1,
   output logic [319:0]  perm_in,
   output logic [7:0]    rc,
   input  logic [319:0]  perm_out,
   output logic          busy,
   output logic          done,
   output logic [63:0]   out0,
   output logic [63:0]   out1,
   output logic [63:0]   tag0,
   output logic [63:0]   tag1
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_AD    = 3'd2;
   localparam logic [2:0] S_PT    = 3'd3;
   localparam logic [2:0] S_FINAL = 3'd4;

   // 12-round phases count 0..11, 6-round phases count 6..11; both end at 11
   localparam logic [3:0] RND_FIRST_FULL = 4'd0;
   localparam logic [3:0] RND_FIRST_HALF = 4'd6;
   localparam logic [3:0] RND_LAST       = 4'd11;
   localparam logic [1:0] BLK_LAST       = 2'd2;

   // control state
   logic [2:0]   state_q, state_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [1:0]   blk_q, blk_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   // cipher state
   logic [319:0] x_q, x_d;

   // operands latched at accept; later input changes are ignored
   logic [63:0]  k0_q, k0_d;
   logic [63:0]  k1_q, k1_d;
   logic [63:0]  ad0_q, ad0_d;
   logic [63:0]  ad1_q, ad1_d;
   logic [63:0]  ad2_q, ad2_d;
   logic [63:0]  pln0_q, pln0_d;
   logic [63:0]  pln1_q, pln1_d;

   // result registers, written only at their own phase-end edges
   logic [63:0]  out0_q, out0_d;
   logic [63:0]  out1_q, out1_d;
   logic [63:0]  tag0_q, tag0_d;
   logic [63:0]  tag1_q, tag1_d;

   // round unit result split into the five state words
   logic [63:0]  y0, y1, y2, y3, y4;
   logic         phase_end;
   logic [63:0]  ad_next;

   assign y0 = perm_out[319:256];
   assign y1 = perm_out[255:192];
   assign y2 = perm_out[191:128];
   assign y3 = perm_out[127:64];
   assign y4 = perm_out[63:0];

   assign phase_end = (rnd_q == RND_LAST);

   // AD word absorbed after the current group: group 0 is followed by d1, group 1 by d2
   assign ad_next = (blk_q == 2'd0) ? ad1_q : ad2_q;

   // round constant for this cycle; IDLE always shows the first constant
   always_comb begin
      rc = 8'hF0;
      if (state_q != S_IDLE) begin
         rc = 8'hF0 - (8'h0F * {4'd0, rnd_q});
      end
   end

   // next-state logic: accept in IDLE, otherwise one round per cycle with phase-end injections
   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      blk_d   = blk_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      x_d     = x_q;
      k0_d    = k0_q;
      k1_d    = k1_q;
      ad0_d   = ad0_q;
      ad1_d   = ad1_q;
      ad2_d   = ad2_q;
      pln0_d  = pln0_q;
      pln1_d  = pln1_q;
      out0_d  = out0_q;
      out1_d  = out1_q;
      tag0_d  = tag0_q;
      tag1_d  = tag1_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               x_d     = {iv, k0, k1, n0, n1};
               k0_d    = k0;
               k1_d    = k1;
               ad0_d   = d0;
               ad1_d   = d1;
               ad2_d   = d2;
               pln0_d  = pln0;
               pln1_d  = pln1;
               rnd_d   = RND_FIRST_FULL;
               blk_d   = 2'd0;
               busy_d  = 1'b1;
               state_d = S_INIT;
            end
         end

         S_INIT: begin
            x_d   = perm_out;
            rnd_d = rnd_q + 4'd1;
            if (phase_end) begin
               // key into the capacity, then absorb the first AD word
               x_d     = {y0 ^ ad0_q, y1, y2, y3 ^ k0_q, y4 ^ k1_q};
               blk_d   = 2'd0;
               rnd_d   = RND_FIRST_HALF;
               state_d = S_AD;
            end
         end

         S_AD: begin
            x_d   = perm_out;
            rnd_d = rnd_q + 4'd1;
            if (phase_end) begin
               rnd_d = RND_FIRST_HALF;
               if (blk_q != BLK_LAST) begin
                  x_d   = {y0 ^ ad_next, y1, y2, y3, y4};
                  blk_d = blk_q + 2'd1;
               end else begin
                  // domain separation bit, then the first plaintext block
                  x_d     = {y0 ^ pln0_q, y1, y2, y3, y4 ^ 64'd1};
                  out0_d  = y0 ^ pln0_q;
                  state_d = S_PT;
               end
            end
         end

         S_PT: begin
            x_d   = perm_out;
            rnd_d = rnd_q + 4'd1;
            if (phase_end) begin
               // last plaintext block, then key into x1/x2 before finalization
               x_d     = {y0 ^ pln1_q, y1 ^ k0_q, y2 ^ k1_q, y3, y4};
               out1_d  = y0 ^ pln1_q;
               rnd_d   = RND_FIRST_FULL;
               state_d = S_FINAL;
            end
         end

         S_FINAL: begin
            x_d   = perm_out;
            rnd_d = rnd_q + 4'd1;
            if (phase_end) begin
               tag0_d  = y3 ^ k0_q;
               tag1_d  = y4 ^ k1_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               rnd_d   = RND_FIRST_FULL;
               state_d = S_IDLE;
            end
         end

         default: begin
            // unreachable encodings recover to IDLE
            state_d = S_IDLE;
            rnd_d   = RND_FIRST_FULL;
            blk_d   = 2'd0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // state registers with synchronous reset that also clears the visible results
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rnd_q   <= 4'd0;
         blk_q   <= 2'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         x_q     <= 320'd0;
         k0_q    <= 64'd0;
         k1_q    <= 64'd0;
         ad0_q   <= 64'd0;
         ad1_q   <= 64'd0;
         ad2_q   <= 64'd0;
         pln0_q  <= 64'd0;
         pln1_q  <= 64'd0;
         out0_q  <= 64'd0;
         out1_q  <= 64'd0;
         tag0_q  <= 64'd0;
         tag1_q  <= 64'd0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         blk_q   <= blk_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         x_q     <= x_d;
         k0_q    <= k0_d;
         k1_q    <= k1_d;
         ad0_q   <= ad0_d;
         ad1_q   <= ad1_d;
         ad2_q   <= ad2_d;
         pln0_q  <= pln0_d;
         pln1_q  <= pln1_d;
         out0_q  <= out0_d;
         out1_q  <= out1_d;
         tag0_q  <= tag0_d;
         tag1_q  <= tag1_d;
      end
   end

   assign perm_in = x_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign out0    = out0_q;
   assign out1    = out1_q;
   assign tag0    = tag0_q;
   assign tag1    = tag1_q;

endmodule

// File: tb/tb_ascon_enc_sequencer.sv
// tb_ascon_enc_sequencer
// Drives the sequencer with either an identity round stub or a full ASCON
// round, and compares results against a message-level ASCON-128 model.
module tb_ascon_enc_sequencer;

   logic          clk;
   logic          rst;
   logic          start;
   logic [63:0]   iv, k0, k1, n0, n1, d0, d1, d2, pln0, pln1;
   logic [319:0]  perm_in;
   logic [7:0]    rc;
   logic [319:0]  perm_out;
   logic          busy, done;
   logic [63:0]   out0, out1, tag0, tag1;

   bit            use_ident;
   int            n_checks;
   int            n_pass;

   ascon_enc_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .iv       (iv),
      .k0       (k0),
      .k1       (k1),
      .n0       (n0),
      .n1       (n1),
      .d0       (d0),
      .d1       (d1),
      .d2       (d2),
      .pln0     (pln0),
      .pln1     (pln1),
      .perm_in  (perm_in),
      .rc       (rc),
      .perm_out (perm_out),
      .busy     (busy),
      .done     (done),
      .out0     (out0),
      .out1     (out1),
      .tag0     (tag0),
      .tag1     (tag1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // one ASCON permutation round: constant addition, S-box layer, linear layer
   function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
      x2 = x2 ^ {56'd0, c};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
      x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
      x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
      x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
      x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   // external round unit
   assign perm_out = use_ident ? perm_in : ascon_round(perm_in, rc);

   // p^n: rounds (12-n)..11 with constant 0xF0 - 0x0F*r
   function automatic logic [319:0] perm_n(input logic [319:0] s, input int nrounds);
      logic [319:0] t;
      t = s;
      for (int r = 12 - nrounds; r < 12; r++) begin
         if (!use_ident) t = ascon_round(t, 8'hF0 - 8'h0F * 8'(r));
      end
      return t;
   endfunction

   // message-level ASCON-128 encryption of 3 AD blocks and 2 plaintext blocks
   task automatic model(input logic [63:0] iv_i, k0_i, k1_i, n0_i, n1_i,
                        input logic [63:0] d0_i, d1_i, d2_i, p0_i, p1_i,
                        output logic [63:0] o0, o1, t0, t1);
      logic [319:0] s;
      logic [63:0]  ad [3];
      ad[0] = d0_i; ad[1] = d1_i; ad[2] = d2_i;
      s = perm_n({iv_i, k0_i, k1_i, n0_i, n1_i}, 12);
      s[127:0] = s[127:0] ^ {k0_i, k1_i};
      for (int b = 0; b < 3; b++) begin
         s[319:256] = s[319:256] ^ ad[b];
         s = perm_n(s, 6);
      end
      s[0] = s[0] ^ 1'b1;
      s[319:256] = s[319:256] ^ p0_i;
      o0 = s[319:256];
      s = perm_n(s, 6);
      s[319:256] = s[319:256] ^ p1_i;
      o1 = s[319:256];
      s[255:128] = s[255:128] ^ {k0_i, k1_i};
      s = perm_n(s, 12);
      t0 = s[127:64] ^ k0_i;
      t1 = s[63:0] ^ k1_i;
   endtask

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic randomize_inputs();
      iv = rnd64(); k0 = rnd64(); k1 = rnd64(); n0 = rnd64(); n1 = rnd64();
      d0 = rnd64(); d1 = rnd64(); d2 = rnd64(); pln0 = rnd64(); pln1 = rnd64();
   endtask

   task automatic set_spec_vector();
      iv = 64'h80400C0600000000; k0 = 64'h265F1C12888E151A; k1 = 64'hC74F26B30A8C44B2;
      n0 = 64'h369C801F3AE8D0EA; n1 = 64'h9BF367D58FD211FF;
      d0 = 64'd0; d1 = 64'd0; d2 = 64'd0;
      pln0 = 64'h1234567890ABCDEF; pln1 = 64'h1234567890ABCDEF;
   endtask

   // mode 0: plain run; mode 1: inputs changed at E5, start pulsed while busy;
   // mode 2: reset applied at E20. Called at a negedge with the DUT idle.
   task automatic do_run(input string name, input int mode, input bit trace);
      logic [63:0] e0, e1, e2, e3;
      logic [7:0]  erc;
      int          cyc, r;
      bit          aborted;
      model(iv, k0, k1, n0, n1, d0, d1, d2, pln0, pln1, e0, e1, e2, e3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq({name, ".busy_after_accept"}, {63'd0, busy}, 64'd1);
      cyc = 0;
      aborted = 1'b0;
      while (!done && cyc < 60) begin
         if (trace && cyc < 48) begin
            r = (cyc < 12) ? cyc : (cyc < 36) ? 6 + (cyc - 12) % 6 : cyc - 36;
            erc = 8'hF0 - 8'h0F * 8'(r);
            check_eq($sformatf("%s.rc%0d", name, cyc), {56'd0, rc}, {56'd0, erc});
         end
         if (mode != 2 && cyc == 30) check_eq({name, ".out0_at_E30"}, out0, e0);
         if (mode == 1 && cyc == 5) randomize_inputs();
         if (mode == 1 && cyc == 10) start = 1'b1;
         if (mode == 1 && cyc == 11) start = 1'b0;
         if (mode == 2 && cyc == 19) rst = 1'b1;
         if (mode == 2 && cyc == 20) begin
            rst = 1'b0;
            check_eq({name, ".rst_busy"}, {63'd0, busy}, 64'd0);
            check_eq({name, ".rst_done"}, {63'd0, done}, 64'd0);
            check_eq({name, ".rst_out0"}, out0, 64'd0);
            check_eq({name, ".rst_out1"}, out1, 64'd0);
            check_eq({name, ".rst_tag0"}, tag0, 64'd0);
            check_eq({name, ".rst_tag1"}, tag1, 64'd0);
            aborted = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      if (!aborted) begin
         check_eq({name, ".latency"}, 64'(cyc), 64'd48);
         check_eq({name, ".busy_in_done"}, {63'd0, busy}, 64'd0);
         check_eq({name, ".out0"}, out0, e0);
         check_eq({name, ".out1"}, out1, e1);
         check_eq({name, ".tag0"}, tag0, e2);
         check_eq({name, ".tag1"}, tag1, e3);
         @(negedge clk);
         check_eq({name, ".done_pulse_len"}, {63'd0, done}, 64'd0);
         check_eq({name, ".out0_hold"}, out0, e0);
      end
      $display("run %s: out0=%h out1=%h tag0=%h tag1=%h cycles=%0d", name, out0, out1, tag0, tag1, cyc);
   endtask

   // start held high: two consecutive runs, 49 cycles apart, with the same results
   task automatic back_to_back(input string name);
      logic [63:0] e0, e1, e2, e3;
      int cyc;
      model(iv, k0, k1, n0, n1, d0, d1, d2, pln0, pln1, e0, e1, e2, e3);
      start = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!done && cyc < 60) begin @(negedge clk); cyc++; end
      check_eq({name, ".first_latency"}, 64'(cyc), 64'd48);
      cyc = 0;
      @(negedge clk); cyc++;
      while (!done && cyc < 60) begin @(negedge clk); cyc++; end
      start = 1'b0;
      check_eq({name, ".interval"}, 64'(cyc), 64'd49);
      check_eq({name, ".out0"}, out0, e0);
      check_eq({name, ".out1"}, out1, e1);
      check_eq({name, ".tag0"}, tag0, e2);
      check_eq({name, ".tag1"}, tag1, e3);
      @(negedge clk);
      check_eq({name, ".idle_after"}, {63'd0, busy}, 64'd0);
      $display("run %s: out0=%h tag0=%h interval=%0d", name, out0, tag0, cyc);
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      use_ident = 1'b1;
      rst = 1'b1;
      start = 1'b0;
      iv = '0; k0 = '0; k1 = '0; n0 = '0; n1 = '0;
      d0 = '0; d1 = '0; d2 = '0; pln0 = '0; pln1 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("reset.busy", {63'd0, busy}, 64'd0);
      check_eq("reset.done", {63'd0, done}, 64'd0);
      check_eq("reset.out0", out0, 64'd0);
      check_eq("reset.tag1", tag1, 64'd0);
      check_eq("reset.x0", perm_in[319:256], 64'd0);
      check_eq("reset.rc", {56'd0, rc}, 64'hF0);

      // identity stub with the reference vector
      set_spec_vector();
      do_run("ident", 0, 1'b1);
      check_eq("ident.kat_out0", out0, 64'h92745A7E90ABCDEF);
      check_eq("ident.kat_out1", out1, 64'h80400C0600000000);
      check_eq("ident.kat_tag0", tag0, 64'h369C801F3AE8D0EA);
      check_eq("ident.kat_tag1", tag1, 64'h9BF367D58FD211FE);

      // input hold and ignored start while busy
      set_spec_vector();
      do_run("hold", 1, 1'b0);
      check_eq("hold.kat_out0", out0, 64'h92745A7E90ABCDEF);
      check_eq("hold.kat_tag1", tag1, 64'h9BF367D58FD211FE);

      // real round unit from here on
      use_ident = 1'b0;
      set_spec_vector();
      d0 = 64'd7895160; d1 = 64'd8882055; d2 = 64'd37008;
      do_run("xmit_vec", 0, 1'b1);

      randomize_inputs();
      do_run("reset_mid", 2, 1'b0);
      do_run("after_reset", 0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         randomize_inputs();
         do_run($sformatf("rand%0d", i), 0, 1'b0);
      end

      randomize_inputs();
      back_to_back("b2b");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ascon_enc_sequencer.md
# ascon_enc_sequencer

Round-serial ASCON-128 encryption controller. It holds the 320-bit ASCON state and sequences one external single-round permutation unit through initialization, associated-data absorption, plaintext encryption and finalization. One round runs per clock. It replaces the fully unrolled combinational transmitter path with a 48-cycle sequential engine. It keeps the transmitter's operand set: IV, 2-word key, 2-word nonce, 3 AD words, 2 plaintext words, 2 ciphertext words.

## Interface
Parameters: none; block counts fixed at 3 AD words, 2 plaintext words, 64-bit rate.
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- iv, k0, k1, n0, n1  in  64 each  IV, key, nonce; latched at accept
- d0, d1, d2  in  64 each  AD blocks, caller-padded; latched at accept
- pln0, pln1  in  64 each  plaintext blocks; latched at accept
- perm_in  out  320  current state {x0,x1,x2,x3,x4}, x0 in bits [319:256]; to round unit
- rc  out  8  round constant for this cycle
- perm_out  in  320  combinational round result of (perm_in, rc)
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse; ciphertext and tag are valid
- out0, out1  out  64 each  ciphertext blocks
- tag0, tag1  out  64 each  authentication tag

## Operation
- FSM states: IDLE, INIT, AD, PT, FINAL. Counters: rnd (0..11) and blk (0..2).
- rc = 0xF0 − 0x0F·rnd (8-bit), giving 0xF0, 0xE1, … 0x4B.
- 12-round phases run rnd 0..11. 6-round phases start at rnd=6.
- Accept, IDLE && start:
  - x = {iv,k0,k1,n0,n1}.
  - Latch all inputs; rnd=0.
  - Go to INIT.
- Each cycle outside IDLE, default edge action: x ← perm_out, rnd++.
- Phase-end edges (rnd==11) replace the default action:
  - INIT end: x ← perm_out ⊕ {0,0,0,k0,k1}, then x0 ^= d0; blk=0, rnd=6; go to AD.
  - AD end, blk<2: x ← perm_out, x0 ^= d[blk+1]; blk++, rnd=6.
  - AD end, blk==2: y=perm_out, y4 ^= 1 (domain separation), y0 ^= pln0; out0 ← y0; x ← y; rnd=6; go to PT.
  - PT end: y=perm_out, y0 ^= pln1; out1 ← y0; y1 ^= k0, y2 ^= k1; x ← y; rnd=0; go to FINAL.
  - FINAL end: tag0 ← perm_out.x3 ⊕ k0, tag1 ← perm_out.x4 ⊕ k1; done ← 1; go to IDLE.
- All key, AD and plaintext terms use the latched copies. Input changes after accept have no effect.
- start while busy is ignored; there is no queue.
- Reset, from any state including mid-run:
  - FSM to IDLE.
  - x, rnd, blk, busy, done, out0, out1, tag0, tag1 all cleared to 0.
- out0, out1, tag0, tag1 change only at their defined edges. They otherwise hold across runs.
- perm_in = x in every state. rc = 0xF0 in IDLE.

## Timing
- Let E0 be the accept edge. Round edges are E1..E48.
- INIT runs E1–E12.
- AD runs E13–E30, in three 6-round groups.
- PT runs E31–E36.
- FINAL runs E37–E48.
- out0 is updated at E30; out1 at E36; tags and done at E48.
- done is high during the cycle after E48, for exactly one cycle. busy is low in that same cycle.
- busy is high during the cycles after E0 through E47.
- Back-to-back: start sampled high in the done cycle is accepted. The next done arrives 48 cycles later.
- The round unit is purely combinational: perm_out depends only on perm_in and rc in the same cycle.

## Test plan
- Identity stub (perm_out = perm_in).
  - Stimulus: iv=0x80400C0600000000, k0=0x265F1C12888E151A, k1=0xC74F26B30A8C44B2, n0=0x369C801F3AE8D0EA, n1=0x9BF367D58FD211FF, d0=d1=d2=0, pln0=pln1=0x1234567890ABCDEF.
  - Required: out0=0x92745A7E90ABCDEF, out1=0x80400C0600000000, tag0=0x369C801F3AE8D0EA, tag1=0x9BF367D58FD211FE.
- Constant and counter sequencing: rc trace across one run must be 0xF0..0x4B (12 values), then 0x96..0x4B four times, then 0xF0..0x4B.
  - done appears exactly 48 cycles after E0.
- Input hold: change every data input at E5 and start at E10 (busy).
  - Required: results identical to the first scenario; no restart occurs.
- Reset: assert rst at E20.
  - Required: the next cycle shows busy=0, done=0, out0=out1=tag0=tag1=0.
  - A fresh start then completes normally in 48 cycles.
- Back-to-back: hold start high continuously.
  - Required: done pulses every 49 cycles; the second run's results match the first.
- Real round unit: the team's ASCON round with the transmitter vector (d0=7895160, d1=8882055, d2=37008).
  - Required: out0/out1 equal the transmitter outputs for the same inputs.
